instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, the PC value loaded on reset.
REQ-002 Parameter: HALT_WORD, 16'hFFFF, the instruction encoding that stops fetch.
REQ-003 Parameter: NOP_WORD, 16'h0000, the instruction value placed in IF/ID for a bubble.
REQ-004 The block has one clock; reset is synchronous and active-high.
REQ-005 Port: Clock, input, 1, rising-edge clock for all state.
REQ-006 Port: Reset, input, 1, synchronous active-high reset.
REQ-007 Port: Stall, input, 1, holds the PC and IF/ID contents.
REQ-008 Port: Flush, input, 1, loads a bubble into IF/ID.
REQ-009 Port: BranchTaken, input, 1, redirects the PC to BranchTarget.
REQ-010 Port: BranchTarget, input, 16, byte address of the redirect; bit 0 is ignored and forced 0.
REQ-011 Port: PC, output, 16, byte address driven to instruction memory Address.
REQ-012 Port: Instruction, input, 16, combinational word returned by instruction memory for PC.
REQ-013 Port: IFID_Instruction, output, 16, registered instruction for decode.
REQ-014 Port: IFID_PCPlus2, output, 16, registered PC+2 of the captured instruction.
REQ-015 Port: IFID_Valid, output, 1, high when the IF/ID contents are a real instruction.
REQ-016 Port: Halted, output, 1, high while in the HALT state.
REQ-017 Port: FetchCount, output, 16, number of instructions delivered with IFID_Valid=1.

Function
REQ-018 The FSM has two states: RUN and HALT. Reset enters RUN; HALT is exited only by Reset.
REQ-019 Priority in RUN, per edge: BranchTaken > Flush > Stall > advance.
REQ-020 Advance (no Stall, Flush, or BranchTaken, and Instruction != HALT_WORD):
  - PC <= PC+2, wrapping from 16'hFFFE to 16'h0000 with no flag.
  - IF/ID <= {Instruction, PC+2, Valid=1}.
REQ-021 BranchTaken=1: PC <= {BranchTarget[15:1],1'b0}, IF/ID <= bubble; this applies regardless of Stall or Flush.
REQ-022 Flush=1 with BranchTaken=0: IF/ID <= bubble; the PC holds if Stall=1 and otherwise advances by 2.
REQ-023 Stall=1 alone: the PC and all IF/ID outputs hold their values.
REQ-024 Bubble = {IFID_Instruction=NOP_WORD, IFID_PCPlus2=0, IFID_Valid=0}.
REQ-025 Instruction==HALT_WORD on an advance edge:
  - State <= HALT; the PC holds.
  - IF/ID <= bubble; the halt word is never forwarded.
REQ-026 In HALT:
  - Halted=1 and the PC is frozen.
  - IF/ID holds a bubble.
  - Stall, Flush, and BranchTaken are ignored.
REQ-027 A HALT_WORD under Stall=1 is not acted on until the edge on which the PC would advance.
REQ-028 FetchCount increments on every edge that loads IFID_Valid=1 and saturates at 16'hFFFF.
REQ-029 PC is a registered output; the block contains no combinational path from Instruction to PC.

Reset
REQ-030 On a Reset edge:
  - PC <= RESET_PC, state <= RUN, Halted <= 0.
  - IF/ID <= bubble, FetchCount <= 0.
REQ-031 Reset overrides all other inputs, including in HALT and in mid-stall.

Verification
REQ-032 Sequential fetch: release reset with memory words 16'h710F at address 0 and 16'h7207 at address 2.
  - Edge 1 -> IFID_Instruction=16'h710F, IFID_PCPlus2=2, PC=2.
  - Edge 2 -> IFID_Instruction=16'h7207, PC=4, FetchCount=2.
REQ-033 Stall: assert Stall for 3 edges at PC=4 -> PC=4 and IF/ID unchanged for all 3 edges; the next edge gives PC=6.
REQ-034 Branch: at PC=8 drive BranchTaken=1, BranchTarget=16'h0003, and Stall=1.
  - Next edge -> PC=16'h0002, IFID_Valid=0, IFID_Instruction=16'h0000.
  - Following edge -> IFID_Instruction=16'h7207.
REQ-035 Halt: place HALT_WORD at address 16'h0012 with 9 normal words before it and run from reset.
  - Edge 10 -> Halted=1, PC=16'h0012, IFID_Valid=0, FetchCount=9.
  - The BranchTaken pulse that follows is ignored.
  - A Reset pulse -> PC=0 and Halted=0.
REQ-036 Wrap and flush: force the PC to 16'hFFFE via BranchTarget, then advance -> PC=16'h0000.
  - Flush=1 with Stall=0 -> IFID_Valid=0 and PC=2.
REQ-037 Saturation: preload FetchCount to 16'hFFFE, then apply 3 advances -> 16'hFFFF, held.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control inputs, instruction memory link and IF/ID outputs of the fetch stage
interface instruction_fetch_if;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] PC;
    logic [15:0] Instruction;
    logic [15:0] IFID_Instruction;
    logic [15:0] IFID_PCPlus2;
    logic        IFID_Valid;
    logic        Halted;
    logic [15:0] FetchCount;
    modport master (
        output Stall, Flush, BranchTaken, BranchTarget, Instruction,
        input  PC, IFID_Instruction, IFID_PCPlus2, IFID_Valid, Halted, FetchCount
    );
    modport slave (
        input  Stall, Flush, BranchTaken, BranchTarget, Instruction,
        output PC, IFID_Instruction, IFID_PCPlus2, IFID_Valid, Halted, FetchCount
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing and IF/ID register with branch, flush, stall and halt handling
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter logic [15:0] NOP_WORD  = 16'h0000
) (
    input  logic Clock,
    input  logic Reset,
    instruction_fetch_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state, state_n;
    logic [15:0] pc, pc_n, ins, ins_n, p2, p2_n, cnt, cnt_n;
    logic        v, v_n, load;
    logic [15:0] pc_inc;
    assign pc_inc = pc + 16'd2;
    // next-state: branch beats flush beats stall beats advance; HALT freezes everything
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ins_n   = ins;
        p2_n    = p2;
        v_n     = v;
        load    = 1'b0;
        if (state == HALT) begin
            ins_n = NOP_WORD;
            p2_n  = 16'h0000;
            v_n   = 1'b0;
        end else if (bus.BranchTaken) begin
            pc_n  = bus.BranchTarget & 16'hFFFE;
            ins_n = NOP_WORD;
            p2_n  = 16'h0000;
            v_n   = 1'b0;
        end else if (bus.Flush) begin
            pc_n  = bus.Stall ? pc : pc_inc;
            ins_n = NOP_WORD;
            p2_n  = 16'h0000;
            v_n   = 1'b0;
        end else if (!bus.Stall) begin
            if (bus.Instruction == HALT_WORD) begin
                state_n = HALT;
                ins_n   = NOP_WORD;
                p2_n    = 16'h0000;
                v_n     = 1'b0;
            end else begin
                pc_n  = pc_inc;
                ins_n = bus.Instruction;
                p2_n  = pc_inc;
                v_n   = 1'b1;
                load  = 1'b1;
            end
        end
        cnt_n = (load && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    end
    // state, PC, IF/ID and delivered-instruction counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            ins   <= NOP_WORD;
            p2    <= 16'h0000;
            v     <= 1'b0;
            cnt   <= 16'h0000;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ins   <= ins_n;
            p2    <= p2_n;
            v     <= v_n;
            cnt   <= cnt_n;
        end
    end
    assign bus.PC               = pc;
    assign bus.IFID_Instruction = ins;
    assign bus.IFID_PCPlus2     = p2;
    assign bus.IFID_Valid       = v;
    assign bus.Halted           = (state == HALT);
    assign bus.FetchCount       = cnt;
endmodule
